// File: rtl/systolic_pkg.sv
// Shared constants and state encoding for the systolic array result drain path.
package systolic_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int N          = 4;
  localparam int RES_WIDTH  = 2 * DATA_WIDTH;
  localparam int IDX_W      = $clog2(N * N);
  localparam int ROW_W      = $clog2(N);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CAPTURE,
    DRAIN
  } drain_state_t;
endpackage

// File: rtl/result_buffer_4x4.sv
// 16-entry result register file: full-row write port, combinational word read port.
module result_buffer_4x4
  import systolic_pkg::*;
(
  input  logic                          clk,
  input  logic                          wr_en,
  input  logic [ROW_W-1:0]              wr_row,
  input  logic [N-1:0][RES_WIDTH-1:0]   wr_data,
  input  logic [IDX_W-1:0]              rd_idx,
  output logic [RES_WIDTH-1:0]          rd_data
);

  logic [RES_WIDTH-1:0] mem [N*N];

  // Lane k of row r lands at entry r*N+k, which is just the concatenation {r, k}.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < N; k++) begin
        mem[{wr_row, ROW_W'(k)}] <= wr_data[k];
      end
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/systolic_result_drain_4x4.sv
// Requests the finished result matrix from the array, captures its four rows and
// streams the 16 words out over a valid/ready port.
module systolic_result_drain_4x4
  import systolic_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 result_ld,
  input  logic                 gd_valid,
  input  logic [RES_WIDTH-1:0] gd0,
  input  logic [RES_WIDTH-1:0] gd1,
  input  logic [RES_WIDTH-1:0] gd2,
  input  logic [RES_WIDTH-1:0] gd3,
  output logic [RES_WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]     out_idx,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  drain_state_t state, next_state;

  logic [ROW_W-1:0]            row_cnt;
  logic [IDX_W-1:0]            word_cnt;
  logic [TO_W-1:0]             wait_cnt;
  logic                        wr_en;
  logic                        timeout_hit;
  logic                        last_accept;
  logic [N-1:0][RES_WIDTH-1:0] lanes;
  logic [RES_WIDTH-1:0]        rd_data;

  assign lanes = {gd3, gd2, gd1, gd0};

  result_buffer_4x4 u_buffer (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_row  (row_cnt),
    .wr_data (lanes),
    .rd_idx  (word_cnt),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state  = state;
    wr_en       = 1'b0;
    timeout_hit = 1'b0;
    last_accept = 1'b0;
    case (state)
      IDLE:    if (start) next_state = REQ;
      REQ:     next_state = WAIT;
      WAIT: begin
        // A row arriving in the final allowed cycle still wins over the timeout.
        if (gd_valid) begin
          wr_en      = 1'b1;
          next_state = CAPTURE;
        end else if (wait_cnt == TO_W'(TIMEOUT - 1)) begin
          timeout_hit = 1'b1;
          next_state  = IDLE;
        end
      end
      CAPTURE: begin
        if (gd_valid) begin
          wr_en = 1'b1;
          if (row_cnt == ROW_W'(N - 1)) next_state = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready && word_cnt == IDX_W'(N * N - 1)) begin
          last_accept = 1'b1;
          next_state  = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Counters restart whenever their owning state is left, so a reset or abort needs no cleanup.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_cnt     <= '0;
      word_cnt    <= '0;
      wait_cnt    <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done        <= last_accept;
      timeout_err <= timeout_hit;
      wait_cnt    <= (state == WAIT) ? wait_cnt + 1'b1 : '0;
      if (state == IDLE)  row_cnt <= '0;
      else if (wr_en)     row_cnt <= row_cnt + 1'b1;
      if (state != DRAIN) word_cnt <= '0;
      else if (out_ready) word_cnt <= word_cnt + 1'b1;
    end
  end

  assign result_ld = (state == REQ);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DRAIN);
  assign out_data  = out_valid ? rd_data : '0;
  assign out_idx   = out_valid ? word_cnt : '0;
  assign out_last  = out_valid && (word_cnt == IDX_W'(N * N - 1));

endmodule

// File: tb/tb_systolic_result_drain_4x4.sv
// Scoreboard bench for systolic_result_drain_4x4: directed matrices, expected words queued, monitor compares.
module tb_systolic_result_drain_4x4;

  localparam int TIMEOUT = 64;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        result_ld;
  logic        gd_valid = 1'b0;
  logic [31:0] gd0 = '0, gd1 = '0, gd2 = '0, gd3 = '0;
  logic [31:0] out_data;
  logic [3:0]  out_idx;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        timeout_err;

  int errors = 0;
  int checks = 0;
  int ld_count = 0;
  int to_count = 0;
  int valid_count = 0;
  exp_word_t exp_q[$];

  systolic_result_drain_4x4 #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .result_ld   (result_ld),
    .gd_valid    (gd_valid),
    .gd0         (gd0),
    .gd1         (gd1),
    .gd2         (gd2),
    .gd3         (gd3),
    .out_data    (out_data),
    .out_idx     (out_idx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expected word per handshake and checks that stalled words hold.
  logic        prev_stall = 1'b0;
  logic [31:0] held_data;
  logic [3:0]  held_idx;
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (result_ld)   ld_count++;
      if (timeout_err) to_count++;
      if (out_valid)   valid_count++;
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_data", out_data, held_data);
        checkOutput("hold_idx", 32'(out_idx), 32'(held_idx));
      end
      prev_stall = out_valid && !out_ready;
      held_data  = out_data;
      held_idx   = out_idx;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got idx %0d data %0d, expected no word", out_idx, out_data);
        end else begin
          exp_word_t e;
          e = exp_q.pop_front();
          checkOutput("word_data", out_data, e.data);
          checkOutput("word_idx", 32'(out_idx), 32'(e.idx));
          checkOutput("word_last", 32'(out_last), 32'(e.last));
        end
      end
    end
  end

  // Queues the expected stream, requests a matrix and feeds its four rows.
  task automatic applyStimulus(input int base, input int gap);
    int ld_before;
    ld_before = ld_count;
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++) begin
        exp_word_t e;
        e.data = 32'(base + 100 * r + k);
        e.idx  = 4'(r * 4 + k);
        e.last = (r * 4 + k == 15);
        exp_q.push_back(e);
      end
    start = 1'b1;
    tick(1);
    start = 1'b0;
    checkOutput("req_result_ld", 32'(result_ld), 32'd1);
    checkOutput("req_busy", 32'(busy), 32'd1);
    tick(1);
    checkOutput("wait_result_ld", 32'(result_ld), 32'd0);
    for (int r = 0; r < 4; r++) begin
      gd_valid = 1'b1;
      gd0 = 32'(base + 100 * r + 0);
      gd1 = 32'(base + 100 * r + 1);
      gd2 = 32'(base + 100 * r + 2);
      gd3 = 32'(base + 100 * r + 3);
      tick(1);
      gd_valid = 1'b0;
      if (r < 3 && gap > 0) tick(gap);
    end
    checkOutput("ld_pulses", 32'(ld_count - ld_before), 32'd1);
  endtask

  // Drains one matrix; optional 1,0,0,1 backpressure and ignored start/gd_valid injection.
  task automatic drainMatrix(input bit bp, input bit inject);
    int cycles;
    int ld_before;
    int to_before;
    bit seen;
    seen = 1'b0;
    cycles = 0;
    ld_before = ld_count;
    to_before = to_count;
    checkOutput("drain_first_valid", 32'(out_valid), 32'd1);
    checkOutput("drain_first_idx", 32'(out_idx), 32'd0);
    for (int i = 0; i < 200 && !seen; i++) begin
      out_ready = bp ? !((i % 4 == 1) || (i % 4 == 2)) : 1'b1;
      if (inject && i == 3) begin
        start = 1'b1;
        gd_valid = 1'b1;
        {gd0, gd1, gd2, gd3} = {4{32'd9999}};
      end else begin
        start = 1'b0;
        gd_valid = 1'b0;
      end
      tick(1);
      cycles = i + 1;
      if (done) seen = 1'b1;
    end
    start = 1'b0;
    gd_valid = 1'b0;
    out_ready = 1'b1;
    checkOutput("done_seen", 32'(seen), 32'd1);
    if (!bp) checkOutput("done_latency", 32'(cycles), 32'd16);
    checkOutput("done_busy", 32'(busy), 32'd0);
    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    tick(1);
    checkOutput("done_one_cycle", 32'(done), 32'd0);
    tick(2);
    checkOutput("no_extra_ld", 32'(ld_count - ld_before), 32'd0);
    checkOutput("idle_after", 32'(busy), 32'd0);
    checkOutput("no_timeout", 32'(to_count - to_before), 32'd0);
  endtask

  initial begin
    tick(2);
    checkOutput("rst_result_ld", 32'(result_ld), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_last", 32'(out_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_timeout", 32'(timeout_err), 32'd0);
    checkOutput("rst_out_data", out_data, 32'd0);
    checkOutput("rst_out_idx", 32'(out_idx), 32'd0);
    rst = 1'b0;
    tick(1);

    $display("[TB] basic drain");
    applyStimulus(0, 0);
    drainMatrix(1'b0, 1'b0);

    $display("[TB] backpressure");
    applyStimulus(0, 0);
    drainMatrix(1'b1, 1'b0);

    $display("[TB] gapped capture");
    applyStimulus(0, 2);
    drainMatrix(1'b0, 1'b0);

    $display("[TB] timeout");
    begin
      int to_before;
      int v_before;
      to_before = to_count;
      v_before = valid_count;
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(TIMEOUT + 2);
      checkOutput("timeout_pulses", 32'(to_count - to_before), 32'd1);
      checkOutput("timeout_busy", 32'(busy), 32'd0);
      checkOutput("timeout_no_valid", 32'(valid_count - v_before), 32'd0);
      checkOutput("timeout_err_low", 32'(timeout_err), 32'd0);
    end

    $display("[TB] reset mid-drain");
    applyStimulus(500, 0);
    tick(6);
    rst = 1'b1;
    exp_q.delete();
    tick(1);
    checkOutput("mrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("mrst_busy", 32'(busy), 32'd0);
    checkOutput("mrst_out_data", out_data, 32'd0);
    checkOutput("mrst_out_idx", 32'(out_idx), 32'd0);
    checkOutput("mrst_out_last", 32'(out_last), 32'd0);
    checkOutput("mrst_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick(1);
    applyStimulus(1000, 0);
    drainMatrix(1'b0, 1'b0);

    $display("[TB] ignored events during drain");
    applyStimulus(2000, 0);
    drainMatrix(1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/systolic_result_drain_4x4.md
# systolic_result_drain_4x4

Result-side companion to `systolic_array_chip_4x4`: where the A/B loaders push operands into the array, this block pulls the finished 4x4 result matrix out. It issues the `result_ld` strobe, captures the four result rows presented on GD0..GD3 into a local buffer, and streams the 16 result words out one per beat over a valid/ready interface. It sits between the array chip and the downstream consumer (a host port or the bench's file writer).

## Interface
- `DATA_WIDTH`, 16, operand width; result words are `2*DATA_WIDTH` bits.
- `N`, 4, array dimension: rows captured and GD lanes per row.
- `TIMEOUT`, 64, cycles allowed in WAIT without `gd_valid` before aborting.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to read a result matrix; ignored unless in IDLE.
- `result_ld`  out  1  strobe to the array chip.
- `gd_valid`  in  1  GD0..GD3 carry one valid result row this cycle.
- `gd0`..`gd3`  in  2*DATA_WIDTH each  result lanes; lane k is column k.
- `out_data`  out  2*DATA_WIDTH  streamed result word.
- `out_idx`  out  4  word index, row*4+col.
- `out_valid`  out  1  `out_data`/`out_idx`/`out_last` valid.
- `out_ready`  in  1  consumer accepts the word this cycle.
- `out_last`  out  1  high with idx 15.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse after the last word is accepted.
- `timeout_err`  out  1  one-cycle pulse when WAIT expires.

## Operation
- States:
  - IDLE: `start` moves to REQ.
  - REQ: one cycle with `result_ld`=1, then WAIT.
  - WAIT: the first `gd_valid` captures row 0 and moves to CAPTURE. If the counter reaches TIMEOUT, pulse `timeout_err` and return to IDLE.
  - CAPTURE: each `gd_valid` cycle captures the next row. Gaps are allowed and do not time out. Capturing row 3 moves to DRAIN.
  - DRAIN: present words idx 0..15 in row-major order. The handshake at idx 15 moves to IDLE and pulses `done`.
- Lane k of captured row r is stored at buffer entry r*4+k. Words are stored verbatim, with no arithmetic and no truncation.
- A word is transferred when `out_valid` and `out_ready` are both high at a rising edge.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_idx` and `out_last` hold stable.
- `out_valid` never drops before its handshake.
- `gd_valid` in IDLE, REQ or DRAIN is ignored; the buffer is not written.
- `start` while `busy`=1 is ignored and not queued.
- `rst` at any time, including mid-CAPTURE or mid-DRAIN, returns to IDLE and discards the partial matrix.
- Reset values: `result_ld`, `out_valid`, `out_last`, `busy`, `done` and `timeout_err` are 0; `out_data` and `out_idx` are 0. Buffer contents are not reset.

## Timing
- `start` sampled at edge t: `result_ld`=1 and `busy`=1 during cycle t+1.
- The WAIT counter starts at 0 on entry and increments once per WAIT cycle. `timeout_err` pulses in the cycle after the counter reaches TIMEOUT, together with the return to IDLE.
- Row 3 captured at edge c: `out_valid`=1 with idx 0 from cycle c+1. There is no bubble between capture and drain.
- With `out_ready` held at 1, one word is transferred per cycle. Idx 15 is accepted at edge c+16; `done`=1 and `busy`=0 in cycle c+17.
- `done` and `start` in the same cycle: `start` is accepted, because the state is already IDLE.
- Throughput: one matrix per (REQ + WAIT + 4 capture cycles + 16 beats + 1) cycles.

## Structure
- Shared package `systolic_pkg` holds:
  - `DATA_WIDTH`, `N`, and `RES_WIDTH = 2*DATA_WIDTH`;
  - the state enum (IDLE, REQ, WAIT, CAPTURE, DRAIN);
  - the index width constant (`$clog2(N*N)`).
- Sub-module `result_buffer_4x4`: a 16x`RES_WIDTH` register file.
  - One write port writes a full row: four lanes at row address r.
  - One combinational read port reads by 4-bit index.
- The top module contains the FSM, the row counter, the word counter and the timeout counter.

## Test plan
- **Basic drain:** `start`, then `gd_valid` for 4 consecutive cycles with row r lane k = 100*r+k, `out_ready`=1 → 16 words 0,1,2,3,100,…,303 with idx 0..15; `out_last` only on 303; `done` one cycle after.
- **Backpressure:** as basic, but `out_ready` toggles 1,0,0,1 → data is held during stalls, no word is lost or duplicated, and the sequence is identical.
- **Gapped capture:** rows arrive with 2 idle cycles between each → same 16 words, no `timeout_err`.
- **Timeout:** `start`, then no `gd_valid` for TIMEOUT+2 cycles → `timeout_err` pulses once, then IDLE, `busy`=0, `out_valid` never asserted.
- **Reset mid-DRAIN** after idx 5 → next cycle all outputs are 0. A new `start` with fresh rows 1000+… drains from idx 0 with the new values.
- **Ignored events:** `start` and `gd_valid` pulsed during DRAIN → no second `result_ld`, buffer unchanged, stream intact.
